// File: rtl/geo_pixel_writer.sv
// geo_pixel_writer
// Consumer end of the geometry pixel stream. Pixels from the line generator
// are buffered in a small FIFO, clipped against the destination bitmap and
// converted to a masked byte write for the selected colour depth.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   pixel_data_rdy      coordinate valid from the line generator
//   X_coord, Y_coord    signed 12-bit pixel coordinates
//   draw_busy           backpressure to the generator (fifo full or reset)
//   color, bpp_sel      pixel colour and colour depth (0=1bpp .. 3=8bpp)
//   dest_base           bitmap base byte address
//   dest_stride         bytes per raster line
//   dest_width/height   clip bounds in pixels
//   wr_req/addr/data/mask, wr_ack   masked write request to the arbiter
//   idle                nothing buffered and no request outstanding
//   clip_count          saturating count of discarded pixels
module geo_pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_data_rdy,
  input  logic [11:0]       X_coord,
  input  logic [11:0]       Y_coord,
  output logic              draw_busy,
  input  logic [7:0]        color,
  input  logic [1:0]        bpp_sel,
  input  logic [ADDR_W-1:0] dest_base,
  input  logic [11:0]       dest_stride,
  input  logic [11:0]       dest_width,
  input  logic [11:0]       dest_height,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        wr_mask,
  input  logic              wr_ack,
  output logic              idle,
  output logic [15:0]       clip_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [31:0]      fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
  logic [PTR_W:0]   fifoCount_q;
  logic             fifoFull, fifoEmpty, push, pop;
  logic [31:0]      rdData;
  logic [11:0]      popX, popY;

  // Stage S1: clip decision and row offset
  logic        s1Valid_q, s1Valid_d;
  logic        s1Clip_q, s1Clip_d;
  logic [22:0] s1Row_q, s1Row_d;
  logic [10:0] s1X_q, s1X_d;
  logic [7:0]  s1Color_q, s1Color_d;
  logic [1:0]  s1Bpp_q, s1Bpp_d;

  // Stage S2: the request register seen by the arbiter
  logic              wrReq_q, wrReq_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]        wrData_q, wrData_d;
  logic [7:0]        wrMask_q, wrMask_d;
  logic [15:0]       clipCount_q, clipCount_d;

  logic        s2Load, s1Advance;
  logic [1:0]  shiftAmt;
  logic [10:0] shiftedX;

  assign fifoFull  = (fifoCount_q == FULL_COUNT);
  assign fifoEmpty = (fifoCount_q == '0);
  assign draw_busy = fifoFull | reset;
  // Fullness comes from the registered count, so a simultaneous pop never
  // lets a new pixel in on the same edge.
  assign push      = pixel_data_rdy & ~draw_busy;

  assign s2Load    = s1Valid_q & ~s1Clip_q & (~wrReq_q | wr_ack);
  assign s1Advance = s1Valid_q & (s1Clip_q | s2Load);
  assign pop       = ~fifoEmpty & (~s1Valid_q | s1Advance);

  assign rdData = fifoMem_q[rdPtr_q];
  assign popX   = rdData[23:12];
  assign popY   = rdData[11:0];

  assign wr_req     = wrReq_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign wr_mask    = wrMask_q;
  assign clip_count = clipCount_q;
  assign idle       = fifoEmpty & ~s1Valid_q & ~wrReq_q;

  // FIFO payload: colour, X, Y packed in one word. No reset needed since
  // entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= {color, X_coord, Y_coord};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + 1'b1;
        2'b01:   fifoCount_q <= fifoCount_q - 1'b1;
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

  // S1 next state. A negative coordinate has bit 11 set; the unsigned
  // compare against the width then handles the upper bound.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Clip_d  = s1Clip_q;
    s1Row_d   = s1Row_q;
    s1X_d     = s1X_q;
    s1Color_d = s1Color_q;
    s1Bpp_d   = s1Bpp_q;
    if (pop) begin
      s1Valid_d = 1'b1;
      s1Clip_d  = popX[11] | popY[11] | (popX >= dest_width) | (popY >= dest_height);
      s1Row_d   = 23'(popY[10:0]) * 23'(dest_stride);
      s1X_d     = popX[10:0];
      s1Color_d = rdData[31:24];
      s1Bpp_d   = bpp_sel;
    end else if (s1Advance) begin
      s1Valid_d = 1'b0;
    end
  end

  // S2 next state: byte address, MSB-first pixel mask and replicated colour.
  always_comb begin
    shiftAmt    = 2'd3 - s1Bpp_q;
    shiftedX    = s1X_q >> shiftAmt;
    wrReq_d     = wrReq_q;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    wrMask_d    = wrMask_q;
    clipCount_d = clipCount_q;
    if (s2Load) begin
      wrReq_d  = 1'b1;
      wrAddr_d = dest_base + ADDR_W'(s1Row_q) + ADDR_W'(shiftedX);
      case (s1Bpp_q)
        2'd0: begin
          wrMask_d = 8'h80 >> s1X_q[2:0];
          wrData_d = {8{s1Color_q[0]}};
        end
        2'd1: begin
          wrMask_d = 8'hC0 >> {s1X_q[1:0], 1'b0};
          wrData_d = {4{s1Color_q[1:0]}};
        end
        2'd2: begin
          wrMask_d = s1X_q[0] ? 8'h0F : 8'hF0;
          wrData_d = {2{s1Color_q[3:0]}};
        end
        default: begin
          wrMask_d = 8'hFF;
          wrData_d = s1Color_q;
        end
      endcase
    end else if (wrReq_q & wr_ack) begin
      wrReq_d = 1'b0;
    end
    if (s1Valid_q & s1Clip_q & (clipCount_q != 16'hFFFF)) begin
      clipCount_d = clipCount_q + 16'd1;
    end
  end

  // Pipeline registers. Reset drops any outstanding request outright.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q   <= 1'b0;
      s1Clip_q    <= 1'b0;
      s1Row_q     <= '0;
      s1X_q       <= '0;
      s1Color_q   <= '0;
      s1Bpp_q     <= '0;
      wrReq_q     <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      wrMask_q    <= '0;
      clipCount_q <= '0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Clip_q    <= s1Clip_d;
      s1Row_q     <= s1Row_d;
      s1X_q       <= s1X_d;
      s1Color_q   <= s1Color_d;
      s1Bpp_q     <= s1Bpp_d;
      wrReq_q     <= wrReq_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      wrMask_q    <= wrMask_d;
      clipCount_q <= clipCount_d;
    end
  end

endmodule

// File: tb/tb_geo_pixel_writer.sv
// tb_geo_pixel_writer
// Self-checking bench for geo_pixel_writer. A reference model turns every
// accepted pixel into either a clip or an expected write, using plain
// arithmetic on the pixel coordinates; a monitor compares the DUT request
// stream against that queue every cycle. Directed scenarios pin latency,
// backpressure depth, clipping, reset and address wrap with literal values.
module tb_geo_pixel_writer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 20;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    logic [7:0]  mask;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              pixel_data_rdy;
  logic [11:0]       X_coord, Y_coord;
  logic              draw_busy;
  logic [7:0]        color;
  logic [1:0]        bpp_sel;
  logic [ADDR_W-1:0] dest_base;
  logic [11:0]       dest_stride, dest_width, dest_height;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data, wr_mask;
  logic              wr_ack;
  logic              idle;
  logic [15:0]       clip_count;

  int errorCount = 0;
  int checkCount = 0;

  // Model state shared between the monitor and the directed checks
  wr_t         expQ[$];
  int          clipModel = 0;
  int          handshakes = 0;
  bit          monitorOn = 0;
  bit          holdPending = 0;
  wr_t         held;
  logic [19:0] lastAddr;
  logic [7:0]  lastMask;

  geo_pixel_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .pixel_data_rdy(pixel_data_rdy), .X_coord(X_coord), .Y_coord(Y_coord),
    .draw_busy(draw_busy), .color(color), .bpp_sel(bpp_sel),
    .dest_base(dest_base), .dest_stride(dest_stride),
    .dest_width(dest_width), .dest_height(dest_height),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_ack(wr_ack), .idle(idle), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checkCount++;
    errorCount++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Pixel -> clip decision or expected write, straight from the bitmap rules:
  // pixels per byte, MSB-first slot inside the byte, colour replicated.
  function automatic void modelPixel(input int x, input int y, input logic [7:0] c,
                                     input int bpp, input longint base, input longint stride,
                                     input int w, input int h,
                                     output bit clipped, output wr_t wr);
    int     bits, ppb, slot, v, d;
    longint a;
    bits    = 1 << bpp;
    ppb     = 8 / bits;
    clipped = (x < 0) || (y < 0) || (x >= w) || (y >= h);
    slot    = (x < 0) ? 0 : x % ppb;
    a       = (base + longint'(y) * stride + longint'((x < 0) ? 0 : x / ppb)) % (longint'(1) << 20);
    wr.addr = 20'(a);
    wr.mask = 8'(((1 << bits) - 1) << (8 - bits * (slot + 1)));
    v       = int'(c) & ((1 << bits) - 1);
    d       = 0;
    for (int k = 0; k < ppb; k++) d = d | (v << (k * bits));
    wr.data = 8'(d);
  endfunction

  // Monitor: samples at the falling edge, where every value equals what the
  // next rising edge will see, then advances the model across that edge.
  always @(negedge clk) begin
    bit  clipped;
    wr_t exp;
    if (monitorOn) begin
      if (holdPending) begin
        checkOutput("holdReq", 32'(wr_req), 32'd1);
        checkOutput("holdAddr", 32'(wr_addr), 32'(held.addr));
        checkOutput("holdData", 32'(wr_data), 32'(held.data));
        checkOutput("holdMask", 32'(wr_mask), 32'(held.mask));
      end
      if (reset) begin
        checkOutput("busyInReset", 32'(draw_busy), 32'd1);
        expQ.delete();
        clipModel   = 0;
        holdPending = 0;
      end else begin
        if (idle) begin
          checkOutput("idleQueueEmpty", 32'(expQ.size()), 32'd0);
          checkOutput("idleClipCount", 32'(clip_count), 32'((clipModel > 16'hFFFF) ? 16'hFFFF : clipModel));
        end
        if (expQ.size() != 0) checkOutput("notIdleWhilePending", 32'(idle), 32'd0);
        if (wr_req) begin
          checkOutput("reqHasPixel", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            checkOutput("wrAddr", 32'(wr_addr), 32'(expQ[0].addr));
            checkOutput("wrData", 32'(wr_data), 32'(expQ[0].data));
            checkOutput("wrMask", 32'(wr_mask), 32'(expQ[0].mask));
          end
        end
        if (wr_req && wr_ack) begin
          handshakes++;
          lastAddr = wr_addr;
          lastMask = wr_mask;
          if (expQ.size() != 0) exp = expQ.pop_front();
        end
        if (pixel_data_rdy && !draw_busy) begin
          modelPixel(int'($signed(X_coord)), int'($signed(Y_coord)), color, int'(bpp_sel),
                     longint'(dest_base), longint'(dest_stride),
                     int'(dest_width), int'(dest_height), clipped, exp);
          if (clipped) clipModel++;
          else expQ.push_back(exp);
        end
        holdPending = wr_req && !wr_ack;
        held.addr   = wr_addr;
        held.data   = wr_data;
        held.mask   = wr_mask;
      end
    end
  end

  // Presents one pixel and returns just after the edge that accepted it.
  task automatic sendPixel(input int x, input int y, input logic [7:0] c);
    int waitCycles = 0;
    bit done = 0;
    pixel_data_rdy = 1'b1;
    X_coord = 12'(x);
    Y_coord = 12'(y);
    color   = c;
    while (!done) begin
      @(negedge clk);
      if (!draw_busy) done = 1;
      else if (++waitCycles > 200) begin
        reportFail("acceptTimeout");
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    pixel_data_rdy = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (idle) done = 1;
      else if (++n > budget) begin
        reportFail("idleTimeout");
        done = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single pixel into an empty pipeline with wr_ack high: no request one
  // cycle after accept, request two cycles after, gone the cycle after that.
  task automatic sendAndCapture(input int x, input int y, input logic [7:0] c,
                                output logic [19:0] a, output logic [7:0] d, output logic [7:0] m);
    sendPixel(x, y, c);
    checkOutput("latencyN", 32'(wr_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("latencyN1", 32'(wr_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("latencyN2", 32'(wr_req), 32'd1);
    a = wr_addr;
    d = wr_data;
    m = wr_mask;
    @(posedge clk); #1;
    checkOutput("singleRequest", 32'(wr_req), 32'd0);
  endtask

  task automatic setConfig(input logic [1:0] bpp, input logic [19:0] base, input logic [11:0] stride,
                           input logic [11:0] w, input logic [11:0] h);
    bpp_sel     = bpp;
    dest_base   = base;
    dest_stride = stride;
    dest_width  = w;
    dest_height = h;
  endtask

  task automatic applyStimulus();
    logic [19:0] a;
    logic [7:0]  d, m;
    bit          clipped;
    wr_t         w;
    int          hsStart, accepted, idx, ackPct, cw, ch;

    // Model pinned against hand-computed values
    modelPixel(10, 2, 8'h01, 0, 64'h1000, 80, 640, 480, clipped, w);
    checkOutput("modelAddr1bpp", 32'(w.addr), 32'h010A1);
    checkOutput("modelMask1bpp", 32'(w.mask), 32'h20);
    modelPixel(4, 1, 8'h5C, 3, 64'hFFFF0, 16, 640, 480, clipped, w);
    checkOutput("modelAddrWrap", 32'(w.addr), 32'h00004);

    // 1bpp write
    wr_ack = 1'b1;
    setConfig(2'd0, 20'h01000, 12'd80, 12'd640, 12'd480);
    sendAndCapture(10, 2, 8'h01, a, d, m);
    checkOutput("bpp1Addr", 32'(a), 32'h010A1);
    checkOutput("bpp1Mask", 32'(m), 32'h20);
    checkOutput("bpp1Data", 32'(d), 32'hFF);
    waitIdle(20);

    // 4bpp writes, odd then even pixel
    setConfig(2'd2, 20'h01000, 12'd160, 12'd640, 12'd480);
    sendAndCapture(5, 3, 8'h0A, a, d, m);
    checkOutput("bpp4Addr", 32'(a), 32'h011E2);
    checkOutput("bpp4MaskOdd", 32'(m), 32'h0F);
    checkOutput("bpp4Data", 32'(d), 32'hAA);
    sendAndCapture(4, 3, 8'h0A, a, d, m);
    checkOutput("bpp4MaskEven", 32'(m), 32'hF0);
    waitIdle(20);

    // 2bpp, slot 2 of the byte
    setConfig(2'd1, 20'h00100, 12'd10, 12'd640, 12'd480);
    sendAndCapture(6, 0, 8'h02, a, d, m);
    checkOutput("bpp2Addr", 32'(a), 32'h00101);
    checkOutput("bpp2Mask", 32'(m), 32'h0C);
    checkOutput("bpp2Data", 32'(d), 32'hAA);
    waitIdle(20);

    // Address wrap
    setConfig(2'd3, 20'hFFFF0, 12'd16, 12'd640, 12'd480);
    sendAndCapture(4, 1, 8'h5C, a, d, m);
    checkOutput("wrapAddr", 32'(a), 32'h00004);
    checkOutput("wrapData", 32'(d), 32'h5C);
    waitIdle(20);

    // Clipping: only the corner pixel survives
    setConfig(2'd3, 20'h02000, 12'd320, 12'd320, 12'd240);
    hsStart = handshakes;
    sendPixel(-1, 0, 8'h11);
    sendPixel(320, 5, 8'h22);
    sendPixel(0, 240, 8'h33);
    sendPixel(319, 239, 8'h44);
    waitIdle(40);
    checkOutput("clipRequests", 32'(handshakes - hsStart), 32'd1);
    checkOutput("clipAddr", 32'(lastAddr), 32'h14BFF);
    checkOutput("clipMask", 32'(lastMask), 32'hFF);
    checkOutput("clipCount", 32'(clip_count), 32'd3);

    // Backpressure: ack held low, generator stalls after DEPTH+2 pixels
    setConfig(2'd3, 20'h03000, 12'd64, 12'd320, 12'd240);
    wr_ack = 1'b0;
    hsStart = handshakes;
    accepted = 0;
    idx = 0;
    pixel_data_rdy = 1'b1;
    X_coord = 12'd0;
    Y_coord = 12'd7;
    color   = 8'h80;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit acc;
      @(negedge clk);
      acc = pixel_data_rdy && !draw_busy;
      @(posedge clk); #1;
      if (acc) begin
        accepted++;
        idx++;
        X_coord = 12'(idx);
        color   = 8'(8'h80 + idx);
      end
    end
    checkOutput("bpAccepts", 32'(accepted), 32'(DEPTH + 2));
    checkOutput("bpBusy", 32'(draw_busy), 32'd1);
    checkOutput("bpReqHeld", 32'(wr_req), 32'd1);
    wr_ack = 1'b1;
    for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
      bit acc;
      @(negedge clk);
      acc = pixel_data_rdy && !draw_busy;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        X_coord = 12'(idx);
        color   = 8'(8'h80 + idx);
      end
    end
    pixel_data_rdy = 1'b0;
    checkOutput("bpAllAccepted", 32'(idx), 32'd10);
    waitIdle(60);
    checkOutput("bpRequests", 32'(handshakes - hsStart), 32'd10);
    checkOutput("bpIdle", 32'(idle), 32'd1);

    // Reset mid-stream: one request pending, three pixels in the FIFO
    wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) sendPixel(20 + i, 9, 8'(i));
    checkOutput("preResetReq", 32'(wr_req), 32'd1);
    checkOutput("preResetClip", 32'(clip_count), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("postResetReq", 32'(wr_req), 32'd0);
    checkOutput("postResetIdle", 32'(idle), 32'd1);
    checkOutput("postResetClip", 32'(clip_count), 32'd0);
    wr_ack = 1'b1;
    hsStart = handshakes;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("noStaleRequest", 32'(handshakes - hsStart), 32'd0);

    // Randomized traffic against the model
    for (int phase = 0; phase < 6; phase++) begin
      cw = int'($urandom_range(400, 1));
      ch = int'($urandom_range(300, 1));
      setConfig(2'($urandom_range(3)), 20'($urandom), 12'($urandom_range(300, 1)), 12'(cw), 12'(ch));
      ackPct = 20 + phase * 15;
      for (int cyc = 0; cyc < 200; cyc++) begin
        pixel_data_rdy = ($urandom_range(99) < 70);
        X_coord = 12'(int'($urandom_range(cw + 40)) - 20);
        Y_coord = 12'(int'($urandom_range(ch + 40)) - 20);
        color   = 8'($urandom);
        wr_ack  = ($urandom_range(99) < ackPct);
        @(posedge clk); #1;
      end
      pixel_data_rdy = 1'b0;
      wr_ack = 1'b1;
      waitIdle(100);
    end
  endtask

  initial begin
    reset = 1'b1;
    pixel_data_rdy = 1'b0;
    X_coord = '0;
    Y_coord = '0;
    color = '0;
    wr_ack = 1'b0;
    setConfig(2'd0, 20'h0, 12'd0, 12'd0, 12'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busyDuringReset", 32'(draw_busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("resetReq", 32'(wr_req), 32'd0);
    checkOutput("resetAddr", 32'(wr_addr), 32'd0);
    checkOutput("resetData", 32'(wr_data), 32'd0);
    checkOutput("resetMask", 32'(wr_mask), 32'd0);
    checkOutput("resetClip", 32'(clip_count), 32'd0);
    checkOutput("resetIdle", 32'(idle), 32'd1);
    checkOutput("resetBusyLow", 32'(draw_busy), 32'd0);
    monitorOn = 1;
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
